// File: rtl/counter_cmd_arbiter.sv
// Button-to-strobe command arbiter for the up/down counter: edge detection, group arbitration, saturation.
// Optional auto-repeat of a held direction button is enabled by defining COUNTER_CMD_AUTO_REPEAT_EN.
module counter_cmd_arbiter #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MAX_VAL       = 255,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned LOAD_VAL      = 22,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       buttons,
  input  logic [WIDTH-1:0] cur_value,
  output logic             inc,
  output logic             dec,
  output logic             load,
  output logic [WIDTH-1:0] load_value,
  output logic             sat,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
    $error("HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  state_t     state;
  logic [4:0] btn_q;
  logic       up, dn, ld;
  logic       up_rise, dn_rise, ld_rise;
  logic       inc_ok, dec_ok;

  always_comb begin
    up      = buttons[0] | buttons[3];
    dn      = buttons[1] | buttons[2];
    ld      = buttons[4];
    up_rise = up & ~(btn_q[0] | btn_q[3]);
    dn_rise = dn & ~(btn_q[1] | btn_q[2]);
    ld_rise = ld & ~btn_q[4];
    inc_ok  = cur_value < MAX_W;
    dec_ok  = cur_value > MIN_W;
  end

  assign load_value = WIDTH'(LOAD_VAL);
  assign state_dbg  = state;

`ifdef COUNTER_CMD_AUTO_REPEAT_EN
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [TW-1:0] timer;
  logic          owner_up;
  logic          owner_level;

  assign owner_level = owner_up ? up : dn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      btn_q    <= '1;
      timer    <= '0;
      owner_up <= 1'b0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      load     <= 1'b0;
      sat      <= 1'b0;
    end else begin
      btn_q <= buttons;
      inc   <= 1'b0;
      dec   <= 1'b0;
      load  <= 1'b0;
      sat   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld_rise) begin
            load  <= 1'b1;
            state <= WAIT_REL;
          end else if (up_rise && dn_rise) begin
            state <= WAIT_REL;
          end else if (up_rise) begin
            inc      <= inc_ok;
            sat      <= ~inc_ok;
            owner_up <= 1'b1;
            timer    <= '0;
            state    <= HOLD;
          end else if (dn_rise) begin
            dec      <= dec_ok;
            sat      <= ~dec_ok;
            owner_up <= 1'b0;
            timer    <= '0;
            state    <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          // Release beats preemption; opposite-group activity is ignored here.
          if (!owner_level) begin
            state <= (buttons == '0) ? IDLE : WAIT_REL;
          end else if (ld_rise) begin
            load  <= 1'b1;
            state <= WAIT_REL;
          end else if ((state == HOLD   && timer == TW'(HOLD_CYCLES - 1)) ||
                       (state == REPEAT && timer == TW'(REPEAT_CYCLES - 1))) begin
            inc   <= owner_up & inc_ok;
            dec   <= ~owner_up & dec_ok;
            sat   <= owner_up ? ~inc_ok : ~dec_ok;
            timer <= '0;
            state <= REPEAT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_REL: begin
          if (buttons == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      btn_q <= '1;
      inc   <= 1'b0;
      dec   <= 1'b0;
      load  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      btn_q <= buttons;
      inc   <= 1'b0;
      dec   <= 1'b0;
      load  <= 1'b0;
      sat   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld_rise) begin
            load  <= 1'b1;
            state <= WAIT_REL;
          end else if (up_rise && dn_rise) begin
            state <= WAIT_REL;
          end else if (up_rise) begin
            inc   <= inc_ok;
            sat   <= ~inc_ok;
            state <= WAIT_REL;
          end else if (dn_rise) begin
            dec   <= dec_ok;
            sat   <= ~dec_ok;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (buttons == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed plus randomized bench for counter_cmd_arbiter against a press/age based reference model.
module tb_counter_cmd_arbiter;

  localparam int HOLD = 4;
  localparam int REP  = 3;
  localparam int MAXV = 255;
  localparam int MINV = 0;
  localparam int LDV  = 22;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] buttons;
  logic [7:0] cur_value;
  logic       inc, dec, load, sat;
  logic [7:0] load_value;
  logic [1:0] state_dbg;

  counter_cmd_arbiter #(
    .WIDTH(8), .MAX_VAL(MAXV), .MIN_VAL(MINV), .LOAD_VAL(LDV),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .cur_value(cur_value),
    .inc(inc), .dec(dec), .load(load), .load_value(load_value),
    .sat(sat), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0 = idle, 1 = owning a held direction, 2 = waiting for all-release.
  logic [4:0] m_prev;
  int         m_mode;
  bit         m_up;
  int         m_age;
  logic       m_inc, m_dec, m_load, m_sat;
  logic [1:0] m_state;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("strobes{inc,dec,load,sat}", {4'b0, inc, dec, load, sat}, {4'b0, m_inc, m_dec, m_load, m_sat});
    chk("state_dbg", {6'b0, state_dbg}, {6'b0, m_state});
  endtask

  task automatic model_reset();
    m_prev = 5'b11111;
    m_mode = 0;
    m_age  = 0;
    m_up   = 1'b0;
    m_inc = 0; m_dec = 0; m_load = 0; m_sat = 0;
    m_state = 2'd0;
  endtask

  task automatic model_grant(input bit up_dir);
    bit ok;
    ok = up_dir ? (int'(cur_value) < MAXV) : (int'(cur_value) > MINV);
    m_inc = up_dir & ok;
    m_dec = !up_dir & ok;
    m_sat = !ok;
  endtask

  task automatic model_step();
    bit up_l, dn_l, ld_l, up_r, dn_r, ld_r, own_l;
    up_l = buttons[0] | buttons[3];
    dn_l = buttons[1] | buttons[2];
    ld_l = buttons[4];
    up_r = up_l && !(m_prev[0] | m_prev[3]);
    dn_r = dn_l && !(m_prev[1] | m_prev[2]);
    ld_r = ld_l && !m_prev[4];
    m_inc = 0; m_dec = 0; m_load = 0; m_sat = 0;
    case (m_mode)
      0: begin
        if (ld_r) begin
          m_load = 1; m_mode = 2;
        end else if (up_r && dn_r) begin
          m_mode = 2;
        end else if (up_r || dn_r) begin
          model_grant(up_r);
          m_up  = up_r;
          m_age = 0;
          m_mode = AR ? 1 : 2;
        end
      end
      1: begin
        own_l = m_up ? up_l : dn_l;
        if (!own_l) m_mode = (buttons == 5'b0) ? 0 : 2;
        else if (ld_r) begin
          m_load = 1; m_mode = 2;
        end else begin
          m_age++;
          if (m_age >= HOLD && (m_age - HOLD) % REP == 0) model_grant(m_up);
        end
      end
      default: if (buttons == 5'b0) m_mode = 0;
    endcase
    m_state = (m_mode == 0) ? 2'd0 : (m_mode == 2) ? 2'd3 : (m_age < HOLD) ? 2'd1 : 2'd2;
    m_prev = buttons;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [4:0] b, input int n);
    buttons = b;
    run(n);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    buttons = 5'b00001;
    cur_value = 8'd100;
    model_reset();
    #12;
    check_all();
    chk("load_value", load_value, 8'(LDV));
    @(negedge clk) reset = 1'b1;

    // b0 held through reset: nothing until released and re-pressed
    run(3);
    press(5'b00000, 2);
    press(5'b00001, 3);
    press(5'b00000, 2);

    // saturation at the upper bound
    cur_value = 8'd254;
    press(5'b01000, 2);
    press(5'b00000, 2);
    cur_value = 8'd255;
    press(5'b00001, 2);
    press(5'b00000, 2);
    cur_value = 8'd0;
    press(5'b00100, 2);
    press(5'b00000, 2);

    // simultaneous up and down
    cur_value = 8'd100;
    press(5'b00011, 4);
    press(5'b00000, 2);

    // load beats a simultaneous down rise
    press(5'b10100, 2);
    chk("load_value", load_value, 8'(LDV));
    press(5'b00000, 2);

    // reset while waiting for release
    press(5'b00010, 2);
    mid_reset();
    press(5'b00010, 2);
    press(5'b00000, 2);

`ifdef COUNTER_CMD_AUTO_REPEAT_EN
    press(5'b00010, 12);
    press(5'b00000, 2);
    press(5'b00001, 8);
    press(5'b10001, 1);
    press(5'b00001, 3);
    press(5'b00000, 2);
    press(5'b00001, 9);
    mid_reset();
    run(2);
    press(5'b00000, 2);
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(4))
          0, 4:    buttons = 5'b00000;
          1:       buttons = 5'(1 << $urandom_range(4));
          2:       buttons = 5'($urandom);
          default: ;
        endcase
      end
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0:       cur_value = 8'd0;
          1:       cur_value = 8'd255;
          2:       cur_value = ($urandom_range(1) == 0) ? 8'd1 : 8'd254;
          default: cur_value = 8'($urandom);
        endcase
      end
      if ($urandom_range(99) == 0) mid_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
